// File: rtl/shader_seq_ctrl.sv
// Shader sequencer: fetches instructions from base_pc, broadcasts each one to the
// enabled lanes, stalls after memory ops, and stops on HALT, abort or PC overflow.
module shader_seq_ctrl #(
    parameter int          LANES    = 4,
    parameter int          PC_W     = 8,
    parameter int          MEM_WAIT = 1,
    parameter logic [5:0]  OP_LOAD  = 6'h01,
    parameter logic [5:0]  OP_STORE = 6'h02,
    parameter logic [5:0]  OP_HALT  = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  base_pc,
    input  logic [LANES-1:0] lane_mask,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic [LANES-1:0] lane_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      issue_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [PC_W-1:0] PC_MAX = '1;

    logic [2:0]       state;
    logic [PC_W-1:0]  pc;
    logic [LANES-1:0] mask;
    logic [2:0]       wait_cnt;
    logic [31:0]      instr_q;
    logic             err_q;
    logic [15:0]      cnt_q;

    logic [5:0] opcode;
    logic       is_mem;
    logic       issue_now;

    assign opcode    = imem_rdata[31:26];
    assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    // An abort arriving in ISSUE cancels that instruction as well.
    assign issue_now = (state == S_ISSUE) && !abort && (opcode != OP_HALT);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            mask     <= '0;
            wait_cnt <= '0;
            instr_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (lane_mask != '0) begin
                            pc    <= base_pc;
                            mask  <= lane_mask;
                            err_q <= 1'b0;
                            cnt_q <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_FETCH: state <= S_ISSUE;
                S_ISSUE: begin
                    if (opcode == OP_HALT) begin
                        state <= S_FIN;
                    end else begin
                        instr_q <= imem_rdata;
                        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                        if (pc == PC_MAX) begin
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            pc <= pc + 1'b1;
                            if (is_mem) begin
                                wait_cnt <= 3'(MEM_WAIT - 1);
                                state    <= S_WAIT;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) state <= S_FETCH;
                    else                wait_cnt <= wait_cnt - 3'd1;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign lane_valid = issue_now ? mask : '0;
    assign instr_out  = issue_now ? imem_rdata : instr_q;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_FIN) && !abort;
    assign err        = err_q;
    assign issue_cnt  = cnt_q;

endmodule

// File: tb/tb_shader_seq_ctrl.sv
// Randomized bench for shader_seq_ctrl: a program-walk reference model predicts the
// issue timeline of each kernel; directed runs cover reset, abort, overflow and zero mask.
module tb_shader_seq_ctrl;

    localparam int MEM_WAIT = 1;
    localparam int MAXK     = 64;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [7:0]  base_pc;
    logic [3:0]  lane_mask;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [3:0]  lane_valid;
    logic        busy, done, err;
    logic [15:0] issue_cnt;

    shader_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_pc    (base_pc),
        .lane_mask  (lane_mask),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_out  (instr_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issue_cnt  (issue_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the address.
    logic [31:0] mem [256];
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state carried across kernels.
    logic [31:0] last_instr;
    int          m_cnt;
    bit          m_err;
    bit          saw_wrap;

    // Expected timeline of one kernel, indexed by cycles after the start edge.
    logic [3:0]  e_lv   [MAXK];
    logic [31:0] e_ins  [MAXK];
    int          e_fetch[MAXK];
    int          e_done;

    function automatic logic [31:0] word(input logic [5:0] op);
        logic [25:0] low;
        low = 26'($urandom);
        return {op, low};
    endfunction

    task automatic build_expect(input logic [7:0] base, input logic [3:0] m);
        int t;
        int pc;
        logic [5:0] op;
        for (int i = 0; i < MAXK; i++) begin
            e_lv[i]    = '0;
            e_ins[i]   = '0;
            e_fetch[i] = -1;
        end
        if (m == 4'h0) begin
            e_done = 0;
            return;
        end
        m_cnt = 0;
        m_err = 1'b0;
        t  = 0;
        pc = int'(base);
        while (1) begin
            e_fetch[t] = pc;
            op = mem[pc][31:26];
            if (op == 6'h3F) begin
                e_done = t + 2;
                break;
            end
            e_lv[t+1]  = m;
            e_ins[t+1] = mem[pc];
            m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
            if (pc == 255) begin
                m_err  = 1'b1;
                e_done = t + 2;
                break;
            end
            t  += (op == 6'h01 || op == 6'h02) ? 2 + MEM_WAIT : 2;
            pc += 1;
        end
    endtask

    task automatic run_kernel(input logic [7:0] base, input logic [3:0] m, input bit ab);
        logic [7:0] prev_addr;
        build_expect(base, m);
        @(negedge clk);
        start     = 1'b1;
        abort     = ab;
        base_pc   = base;
        lane_mask = m;
        @(negedge clk);
        abort     = 1'b0;
        prev_addr = 8'h00;
        for (int k = 0; k <= e_done + 1; k++) begin
            check("lane_valid", 32'(lane_valid), 32'(e_lv[k]));
            if (e_lv[k] != 4'h0) last_instr = e_ins[k];
            check("instr_out", instr_out, last_instr);
            check("done", 32'(done), 32'(k == e_done));
            check("busy", 32'(busy), 32'(k <= e_done));
            if (e_fetch[k] >= 0) check("imem_addr", 32'(imem_addr), 32'(e_fetch[k]));
            if (k > 0 && prev_addr == 8'hFF && imem_addr == 8'h00) saw_wrap = 1'b1;
            prev_addr = imem_addr;
            // Start while busy must be ignored; base/mask only matter at start.
            start     = (k < e_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            base_pc   = 8'($urandom);
            lane_mask = 4'($urandom);
            @(negedge clk);
        end
        check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic load_prog(input logic [7:0] base, input int len);
        int r;
        for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      mem[8'(base + i)] = word(6'h01);
            else if (r == 1) mem[8'(base + i)] = word(6'h02);
            else             mem[8'(base + i)] = word(6'($urandom_range(3, 62)));
        end
        mem[8'(base + len)] = word(6'h3F);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'h0);
        check({tag, "_instr_out"}, instr_out, 32'h0);
        check({tag, "_lane_valid"}, 32'(lane_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_issue_cnt"}, 32'(issue_cnt), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {6'h3F, 26'h0};
        last_instr = '0;
        m_cnt      = 0;
        m_err      = 1'b0;
        saw_wrap   = 1'b0;
        base_pc    = 8'h55;
        lane_mask  = 4'hF;

        // Reset must override a simultaneous start and abort.
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);

        // Zero mask: done next cycle, nothing issued.
        run_kernel(8'h77, 4'h0, 1'b0);

        // Basic run: two ALU ops then HALT.
        mem[8'h10] = word(6'h05);
        mem[8'h11] = word(6'h05);
        mem[8'h12] = word(6'h3F);
        run_kernel(8'h10, 4'hF, 1'b0);

        // Memory stall after LOAD; abort together with start must lose.
        mem[8'h00] = word(6'h01);
        mem[8'h01] = word(6'h07);
        mem[8'h02] = word(6'h3F);
        run_kernel(8'h00, 4'hA, 1'b1);

        // PC overflow at the last address.
        mem[8'hFF] = word(6'h09);
        saw_wrap = 1'b0;
        run_kernel(8'hFF, 4'h3, 1'b0);
        check("no_pc_wrap", 32'(saw_wrap), 32'h0);

        // Abort while stalled after a STORE.
        mem[8'h40] = word(6'h02);
        mem[8'h41] = word(6'h05);
        mem[8'h42] = word(6'h3F);
        @(negedge clk);
        start = 1'b1; base_pc = 8'h40; lane_mask = 4'hF;
        @(negedge clk);                 // FETCH
        start = 1'b0;
        check("abort_fetch_addr", 32'(imem_addr), 32'h40);
        @(negedge clk);                 // ISSUE
        check("abort_issue_lv", 32'(lane_valid), 32'hF);
        last_instr = mem[8'h40];
        @(negedge clk);                 // WAIT
        check("abort_wait_lv", 32'(lane_valid), 32'h0);
        check("abort_wait_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_cnt = 1;
        m_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_busy", 32'(busy), 32'h0);
            check("abort_done", 32'(done), 32'h0);
            check("abort_lv", 32'(lane_valid), 32'h0);
            check("abort_instr_out", instr_out, last_instr);
            check("abort_issue_cnt", 32'(issue_cnt), 32'(m_cnt));
            @(negedge clk);
        end

        // Reset during ISSUE, then a fresh kernel at 0x20.
        mem[8'h30] = word(6'h05);
        mem[8'h31] = word(6'h05);
        mem[8'h32] = word(6'h3F);
        start = 1'b1; base_pc = 8'h30; lane_mask = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                 // ISSUE
        check("rst_issue_lv", 32'(lane_valid), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        last_instr = '0;
        m_cnt      = 0;
        m_err      = 1'b0;
        mem[8'h20] = word(6'h02);
        mem[8'h21] = word(6'h3F);
        run_kernel(8'h20, 4'h6, 1'b0);

        // Randomized kernels.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            logic [3:0] m;
            b = 8'($urandom_range(0, 208));
            m = 4'($urandom);
            load_prog(b, int'($urandom_range(1, 8)));
            run_kernel(b, m, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shader_seq_ctrl.md
SHADER_SEQ_CTRL -- requirements
Module: shader_seq_ctrl

Interface
REQ-001 SHALL take parameter LANES, default 4: number of shader lanes driven.
REQ-002 SHALL take parameter PC_W, default 8: instruction-memory address width.
REQ-003 SHALL take parameter MEM_WAIT, default 1, range 1..7: stall cycles after each OP_LOAD/OP_STORE issue.
REQ-004 SHALL take parameters OP_LOAD=6'h01, OP_STORE=6'h02, OP_HALT=6'h3F: opcodes in instr[31:26].
REQ-005 clk  in  1  rising-edge clock; the only clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begin kernel; sampled only in IDLE.
REQ-008 abort  in  1  cancel the running kernel.
REQ-009 base_pc  in  PC_W  first instruction address, captured with start.
REQ-010 lane_mask  in  LANES  enabled lanes, captured with start.
REQ-011 imem_addr  out  PC_W  instruction-memory read address.
REQ-012 imem_rdata  in  32  instruction word, valid one cycle after imem_addr is presented.
REQ-013 instr_out  out  32  instruction broadcast to all lanes.
REQ-014 lane_valid  out  LANES  per-lane issue strobe.
REQ-015 busy  out  1  kernel in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  sticky PC-overflow flag.
REQ-018 issue_cnt  out  16  instructions issued in the current kernel, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT and FIN.
REQ-020 IDLE, start=1, lane_mask!=0: SHALL latch base_pc into pc and lane_mask into mask, clear err and issue_cnt, and go to FETCH.
REQ-021 IDLE, start=1, lane_mask==0: SHALL go to FIN with no fetch and no issue.
REQ-022 FETCH: SHALL drive imem_addr=pc, hold lane_valid=0, and go to ISSUE next cycle.
REQ-023 ISSUE, opcode==OP_HALT: SHALL not issue (lane_valid=0) and SHALL go to FIN.
REQ-024 ISSUE, any other opcode: SHALL drive instr_out=imem_rdata and lane_valid=mask for exactly this cycle, and SHALL increment issue_cnt, saturating at 16'hFFFF.
REQ-025 ISSUE, OP_LOAD or OP_STORE: SHALL go to WAIT for exactly MEM_WAIT cycles, then go to FETCH with pc+1.
REQ-026 ISSUE, other non-HALT opcode: SHALL go directly to FETCH with pc+1, giving one issue per 2 cycles.
REQ-027 Non-HALT issue at pc == 2^PC_W-1: the instruction SHALL still issue, then the FSM SHALL set err=1 and go to FIN instead of wrapping pc.
REQ-028 FIN: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-029 busy SHALL be 1 in FETCH, ISSUE, WAIT and FIN, and 0 in IDLE.
REQ-030 abort=1 in any non-IDLE state: SHALL go to IDLE next cycle with lane_valid=0, no done pulse, and err and issue_cnt held.
REQ-031 abort and start asserted together in IDLE: start SHALL win.
REQ-032 start in a non-IDLE state SHALL be ignored.
REQ-033 instr_out SHALL hold its last issued value when lane_valid=0.
REQ-034 lane_valid SHALL never be nonzero outside ISSUE.

Reset
REQ-035 rst=1 at a clock edge SHALL force state=IDLE, pc=0, mask=0, imem_addr=0, instr_out=0, lane_valid=0, busy=0, done=0, err=0 and issue_cnt=0, overriding start and abort.
REQ-036 rst asserted mid-kernel SHALL cancel the kernel with no done pulse; a start one cycle after rst deasserts SHALL be accepted.

Verification
REQ-037 Basic run: start, base_pc=8'h10, mask=4'hF; ADD@10, ADD@11, HALT@12 -> lane_valid=4'hF twice, 2 cycles apart; done 1 cycle after the HALT fetch data; issue_cnt=2.
REQ-038 Memory stall: LOAD@0, ADD@1, HALT@2, MEM_WAIT=1 -> gap between the two issue strobes is 3 cycles; issue_cnt=2.
REQ-039 Overflow: base_pc=8'hFF, ADD@FF -> one issue, then err=1 and a done pulse; imem_addr never shows 8'h00 after 8'hFF.
REQ-040 Zero mask: start with lane_mask=0 -> done on the next cycle, lane_valid never nonzero, issue_cnt=0.
REQ-041 Abort: abort in WAIT after a STORE -> IDLE next cycle, done stays 0, busy=0, issue_cnt=1.
REQ-042 Reset mid-kernel: rst during ISSUE -> all outputs 0 next cycle; a new start with base_pc=8'h20 sets imem_addr=8'h20 in FETCH.
